quad_decoder_n: RTL and testbench

Parametrised quadrature (rotation-direction) decoder. It is the successor to the current two-phase direction detector in the TinyTapeout top level.
- Synchronises and debounces two phase inputs (A, B).
- Decodes Gray-code transitions in x1 or x4 mode.
- Keeps a signed position counter with selectable wrap or saturate.
- Flags illegal double-phase transitions.
- Sits between the ui_in phase pins and the display/register logic driving uo_out.

---
 rtl/quad_decoder_n_pkg.sv | 25 ++
 rtl/quad_decoder_n_debounce.sv | 50 +++++
 rtl/quad_decoder_n.sv | 129 ++++++++++++
 tb/tb_quad_decoder_n.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_decoder_n_pkg.sv
// Shared types and helpers for the quadrature decoder.
package quad_pkg;

  // Debounced {A,B} phase state; CW order is S00 -> S01 -> S11 -> S10 -> S00.
  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } phase_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Expected forward (CW) successor of a phase state.
  function automatic phase_t next_cw(input phase_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

endpackage

// File: rtl/quad_decoder_n_debounce.sv
// Per-phase synchroniser followed by a consecutive-cycle debounce filter.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  output logic filt
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign filt   = r_filt;

  // Synchroniser shift chain for the asynchronous phase input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  // Accept a new level only after DEB_CYC consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (load) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else if (w_sync == r_filt) begin
      r_cnt  <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_filt <= w_sync;
      r_cnt  <= '0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_decoder_n.sv
// Quadrature decoder: debounced A/B phases, x1/x4 decode, signed position.
module quad_decoder_n
  import quad_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEB_CYC     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int X4          = 1,
  parameter int WRAP        = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    ph_a,
  input  logic                    ph_b,
  input  logic                    clr,
  output logic signed [CNT_W-1:0] pos,
  output logic                    dir,
  output logic                    step,
  output logic                    err,
  output logic [1:0]              ab_filt
);

  // Filters load directly for SYNC_STAGES+1 edges; decode stays inhibited
  // one edge longer so prev has caught up with the loaded filter value.
  localparam int ST_LAST = SYNC_STAGES + 2;
  localparam int ST_W    = $clog2(ST_LAST + 1);

  localparam logic signed [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [ST_W-1:0]         r_start;
  logic                    w_load;
  logic                    w_inhibit;
  logic                    w_fa;
  logic                    w_fb;
  phase_t                  w_cur;
  phase_t                  r_prev;
  logic                    w_fwd;
  logic                    w_rev;
  logic                    w_ill;
  logic                    w_count;
  logic                    w_err_set;
  logic signed [CNT_W-1:0] w_pos_nxt;
  logic signed [CNT_W-1:0] r_pos;
  logic                    r_dir;
  logic                    r_step;
  logic                    r_err;

  assign w_load    = (r_start < ST_W'(SYNC_STAGES + 1));
  assign w_inhibit = (r_start != ST_W'(ST_LAST));

  // Startup window counter, saturates once decoding is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_start <= '0;
    else if (w_inhibit) r_start <= r_start + ST_W'(1);
  end

  quad_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYC     (DEB_CYC)
  ) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ph_a),
    .load  (w_load),
    .filt  (w_fa)
  );

  quad_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYC     (DEB_CYC)
  ) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (ph_b),
    .load  (w_load),
    .filt  (w_fb)
  );

  assign ab_filt = {w_fa, w_fb};
  assign w_cur   = phase_t'(ab_filt);

  // Classify the prev -> current transition and compute the next position.
  always_comb begin
    w_fwd     = (w_cur != r_prev) && (w_cur == next_cw(r_prev));
    w_rev     = (w_cur != r_prev) && (r_prev == next_cw(w_cur));
    w_ill     = (w_cur != r_prev) && !w_fwd && !w_rev;
    w_count   = 1'b0;
    w_err_set = 1'b0;
    if (!w_inhibit) begin
      // x1 counts only legal entries into 00: from 10 is CW, from 01 is CCW.
      w_count   = ena && (w_fwd || w_rev) && ((X4 != 0) || (w_cur == S00));
      w_err_set = w_ill;
    end
    w_pos_nxt = r_pos;
    if (w_fwd) begin
      if (!((WRAP == 0) && (r_pos == POS_MAX))) w_pos_nxt = r_pos + ONE;
    end else if (w_rev) begin
      if (!((WRAP == 0) && (r_pos == POS_MIN))) w_pos_nxt = r_pos - ONE;
    end
  end

  // Prev tracking, position, direction, step pulse and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= S00;
      r_pos  <= '0;
      r_dir  <= DIR_CCW;
      r_step <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_prev <= w_cur;
      r_step <= w_count && !clr;
      if (w_count) r_dir <= w_fwd ? DIR_CW : DIR_CCW;
      if (clr)          r_pos <= '0;
      else if (w_count) r_pos <= w_pos_nxt;
      if (clr)            r_err <= 1'b0;
      else if (w_err_set) r_err <= 1'b1;
    end
  end

  assign pos  = r_pos;
  assign dir  = r_dir;
  assign step = r_step;
  assign err  = r_err;

endmodule

// File: tb/tb_quad_decoder_n.sv
// Randomised self-checking bench for quad_decoder_n across four configurations.
module tb_quad_decoder_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic ph_a = 1'b0;
  logic ph_b = 1'b0;
  logic clr = 1'b0;

  logic signed [7:0] pos_m;
  logic signed [3:0] pos_s, pos_w, pos_x;
  logic [3:0] dir_v, step_v, err_v;
  logic [1:0] ab_m, ab_s, ab_w, ab_x;

  always #5 clk = ~clk;

  // 0: 8-bit x4 wrap, 1: 4-bit x4 saturate, 2: 4-bit x4 wrap, 3: 4-bit x1 wrap
  quad_decoder_n #(.CNT_W(8), .DEB_CYC(4), .SYNC_STAGES(2), .X4(1), .WRAP(1)) u_m (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ph_a(ph_a), .ph_b(ph_b), .clr(clr),
    .pos(pos_m), .dir(dir_v[0]), .step(step_v[0]), .err(err_v[0]), .ab_filt(ab_m));
  quad_decoder_n #(.CNT_W(4), .DEB_CYC(4), .SYNC_STAGES(2), .X4(1), .WRAP(0)) u_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ph_a(ph_a), .ph_b(ph_b), .clr(clr),
    .pos(pos_s), .dir(dir_v[1]), .step(step_v[1]), .err(err_v[1]), .ab_filt(ab_s));
  quad_decoder_n #(.CNT_W(4), .DEB_CYC(4), .SYNC_STAGES(2), .X4(1), .WRAP(1)) u_w (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ph_a(ph_a), .ph_b(ph_b), .clr(clr),
    .pos(pos_w), .dir(dir_v[2]), .step(step_v[2]), .err(err_v[2]), .ab_filt(ab_w));
  quad_decoder_n #(.CNT_W(4), .DEB_CYC(4), .SYNC_STAGES(2), .X4(0), .WRAP(1)) u_x (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ph_a(ph_a), .ph_b(ph_b), .clr(clr),
    .pos(pos_x), .dir(dir_v[3]), .step(step_v[3]), .err(err_v[3]), .ab_filt(ab_x));

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Observed step pulses per instance.
  int nstep [4] = '{0, 0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (step_v[i]) nstep[i]++;
  end

  // Reference model: shaft index k on the Gray cycle, expected pos/dir/steps/err.
  int k = 0;
  int ep [4] = '{0, 0, 0, 0};
  bit ed [4] = '{0, 0, 0, 0};
  int es [4] = '{0, 0, 0, 0};
  bit exp_err = 1'b0;

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 4;
  endfunction
  function automatic bit wraps(input int i);
    return (i != 1);
  endfunction
  function automatic bit x4m(input int i);
    return (i != 3);
  endfunction
  function automatic logic [1:0] gray(input int idx);
    case (idx)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Add d to p in a w-bit signed range, wrapping or clamping.
  function automatic int arith(input int p, input int d, input int w, input bit wr);
    int hi, lo, q;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    q = p + d;
    if (q > hi) q = wr ? lo : hi;
    if (q < lo) q = wr ? hi : lo;
    return q;
  endfunction

  function automatic int gpos(input int i);
    case (i)
      0:       return int'(pos_m);
      1:       return int'(pos_s);
      2:       return int'(pos_w);
      default: return int'(pos_x);
    endcase
  endfunction

  // Rotate one Gray step, update the model, then wait gap cycles.
  task automatic move(input bit cw, input int gap, output int lat);
    int kn;
    bit cnt;
    kn = cw ? (k + 1) % 4 : (k + 3) % 4;
    for (int i = 0; i < 4; i++) begin
      cnt = x4m(i) ? 1'b1 : (kn == 0);
      if (cnt && ena) begin
        ep[i] = arith(ep[i], cw ? 1 : -1, wid(i), wraps(i));
        ed[i] = cw;
        es[i]++;
      end
    end
    k = kn;
    @(negedge clk);
    {ph_a, ph_b} = gray(k);
    lat = 0;
    for (int c = 1; c <= gap; c++) begin
      @(negedge clk);
      if (lat == 0 && step_v[0]) lat = c;
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_pos%0d", tag, i), gpos(i), ep[i]);
      chk($sformatf("%s_dir%0d", tag, i), int'(dir_v[i]), int'(ed[i]));
      chk($sformatf("%s_steps%0d", tag, i), nstep[i], es[i]);
      chk($sformatf("%s_err%0d", tag, i), int'(err_v[i]), int'(exp_err));
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) ep[i] = 0;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  int lat;

  initial begin
    // Reset state
    #12;
    check_all("reset");
    chk("reset_ab", int'(ab_m), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (10) @(negedge clk);

    // 4 full CW cycles, 20 clocks apart; first step latency 2+4+1
    for (int n = 0; n < 16; n++) begin
      move(1'b1, 20, lat);
      if (n == 0) chk("latency", lat, 7);
    end
    check_all("cw");

    // 2 full CCW cycles
    for (int n = 0; n < 8; n++) move(1'b0, 20, lat);
    check_all("ccw");

    // 3-clock glitch on A is rejected
    @(negedge clk);
    ph_a = ~ph_a;
    repeat (3) @(negedge clk);
    ph_a = ~ph_a;
    repeat (15) @(negedge clk);
    check_all("glitch");
    chk("glitch_ab", int'(ab_m), int'(gray(k)));

    // Limits: 10 CW steps from 0
    pulse_clr();
    check_all("clr0");
    for (int n = 1; n <= 10; n++) begin
      move(1'b1, 12, lat);
      if (n == 8) check_all("lim8");
    end
    check_all("lim10");

    // Illegal double-phase transition, sticky until clr
    k = (k + 2) % 4;
    @(negedge clk);
    {ph_a, ph_b} = gray(k);
    repeat (20) @(negedge clk);
    exp_err = 1'b1;
    check_all("illegal");
    repeat (30) @(negedge clk);
    check_all("sticky");
    pulse_clr();
    check_all("clr1");

    // ena low: tracking only, no counts; re-enable gives no spurious step
    ena = 1'b0;
    for (int n = 0; n < 4; n++) move(1'b1, 12, lat);
    check_all("ena0");
    ena = 1'b1;
    repeat (20) @(negedge clk);
    check_all("ena1");

    // Randomised rotation with random enable and sub-threshold glitches
    for (int n = 0; n < 60; n++) begin
      ena = ($urandom_range(0, 3) != 0);
      move(1'(($urandom_range(0, 1))), $urandom_range(9, 16), lat);
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        if ($urandom_range(0, 1) == 1) ph_a = ~ph_a; else ph_b = ~ph_b;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        {ph_a, ph_b} = gray(k);
        repeat (8) @(negedge clk);
      end
      check_all($sformatf("rnd%0d", n));
    end

    // Reset mid-rotation with the shaft resting at 11
    ena = 1'b1;
    for (int n = 0; n < 4 && k != 2; n++) move(1'b1, 12, lat);
    chk("at11", k, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      ep[i] = 0;
      ed[i] = 1'b0;
    end
    exp_err = 1'b0;
    check_all("rst_low");
    chk("rst_low_ab", int'(ab_m), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_all("rst_rel");
    chk("rst_rel_ab", int'(ab_m), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
